// File: rtl/txpippm_step_sequencer.sv
// txpippm_step_sequencer
//   Command-side initiator for the per-channel TX phase-interpolator PPM
//   controllers. Accepts one request (channel mask, step size, pulse count),
//   emits that many single-cycle PPM pulses spaced PULSE_INTERVAL cycles apart
//   on the shared sel/pulse/stepsize bus, then strobes done (with an abort
//   flag). Runs entirely in the TXUSRCLK domain.
//
// Ports
//   gtwiz_userclk_tx_usrclk_in  clock (TXUSRCLK)
//   gtwiz_reset_all_n_in        async active-low reset
//   gtwiz_userclk_tx_active_in  TX clock active; low aborts / holds idle
//   req_valid_in/req_ready_out  request handshake
//   req_sel_in/stepsize/count   request payload
//   abort_in                    abort the in-flight request
//   sel_out/pulse_out/stepsize_out  bus to the PPM controllers
//   busy_out, done_out, aborted_out, pulses_issued_out  status
//   ppm_offset_out              signed cumulative offset (0 unless enabled)
//
// Configuration
//   TXPIPPM_STEP_SEQUENCER_ACCUM_EN  enables the saturating 24-bit signed
//   offset accumulator behind ppm_offset_out.
module txpippm_step_sequencer #(
  parameter int CHANNEL_COUNT  = 10,
  parameter int COUNT_WIDTH    = 16,
  parameter int PULSE_INTERVAL = 16
) (
  input  logic                     gtwiz_userclk_tx_usrclk_in,
  input  logic                     gtwiz_reset_all_n_in,
  input  logic                     gtwiz_userclk_tx_active_in,
  input  logic                     req_valid_in,
  output logic                     req_ready_out,
  input  logic [CHANNEL_COUNT-1:0] req_sel_in,
  input  logic [4:0]               req_stepsize_in,
  input  logic [COUNT_WIDTH-1:0]   req_count_in,
  input  logic                     abort_in,
  output logic [CHANNEL_COUNT-1:0] sel_out,
  output logic                     pulse_out,
  output logic [4:0]               stepsize_out,
  output logic                     busy_out,
  output logic                     done_out,
  output logic                     aborted_out,
  output logic [COUNT_WIDTH-1:0]   pulses_issued_out,
  output logic signed [23:0]       ppm_offset_out
);

  localparam int WAIT_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT, S_DONE} state_t;

  logic clk, rst_n;
  assign clk   = gtwiz_userclk_tx_usrclk_in;
  assign rst_n = gtwiz_reset_all_n_in;

  state_t                   state_q, state_d;
  logic [CHANNEL_COUNT-1:0] sel_q, sel_d;
  logic [4:0]               step_q, step_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic [COUNT_WIDTH-1:0]   issued_q, issued_d;
  logic [WAIT_W-1:0]        wait_q, wait_d;
  logic                     aborted_q, aborted_d;
  // Holds ready low while reset is asserted; rises on the first clock after
  // release so the handshake never sees the reset-state IDLE as "ready".
  logic                     ready_en_q;

  logic abort_req, accept;

  assign abort_req     = abort_in | ~gtwiz_userclk_tx_active_in;
  assign req_ready_out = ready_en_q & gtwiz_userclk_tx_active_in & (state_q == S_IDLE);
  assign accept        = req_valid_in & req_ready_out;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    step_d    = step_q;
    count_d   = count_q;
    issued_d  = issued_q;
    wait_d    = wait_q;
    aborted_d = aborted_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          sel_d     = req_sel_in;
          step_d    = req_stepsize_in;
          count_d   = req_count_in;
          issued_d  = '0;
          aborted_d = 1'b0;
          state_d   = (req_count_in == '0) ? S_DONE : S_PULSE;
        end
      end
      S_PULSE: begin
        // The pulse on the bus this cycle counts even if it is being aborted.
        issued_d = issued_q + COUNT_WIDTH'(1);
        wait_d   = WAIT_W'(PULSE_INTERVAL - 1);
        if (abort_req) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        wait_d = wait_q - WAIT_W'(1);
        // Abort is tested first so it wins over the final expiry.
        if (abort_req) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (wait_q == WAIT_W'(1)) begin
          state_d = (issued_q == count_q) ? S_DONE : S_PULSE;
        end
      end
      S_DONE: begin
        sel_d   = '0;
        step_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      step_q     <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      wait_q     <= '0;
      aborted_q  <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      step_q     <= step_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      wait_q     <= wait_d;
      aborted_q  <= aborted_d;
      ready_en_q <= 1'b1;
    end
  end

  assign sel_out           = sel_q;
  assign stepsize_out      = step_q;
  assign pulse_out         = (state_q == S_PULSE);
  assign done_out          = (state_q == S_DONE);
  assign busy_out          = (state_q != S_IDLE);
  assign aborted_out       = (state_q == S_DONE) & aborted_q;
  assign pulses_issued_out = issued_q;

`ifdef TXPIPPM_STEP_SEQUENCER_ACCUM_EN
  logic signed [23:0] acc_q;
  logic signed [24:0] acc_sum;
  logic signed [24:0] mag;

  always_comb begin
    mag     = $signed({21'd0, step_q[3:0]});
    acc_sum = step_q[4] ? ($signed({acc_q[23], acc_q}) - mag)
                        : ($signed({acc_q[23], acc_q}) + mag);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (state_q == S_PULSE) begin
      // Bits 24/23 disagree only on overflow; bit 24 gives the direction.
      if (acc_sum[24] != acc_sum[23])
        acc_q <= acc_sum[24] ? 24'sh800000 : 24'sh7FFFFF;
      else
        acc_q <= acc_sum[23:0];
    end
  end

  assign ppm_offset_out = acc_q;
`else
  assign ppm_offset_out = '0;
`endif

endmodule

// File: tb/tb_txpippm_step_sequencer.sv
module tb_txpippm_step_sequencer;
  localparam int CH = 10, CW = 16, PI = 16;
`ifdef TXPIPPM_STEP_SEQUENCER_ACCUM_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0, tx_act = 1'b0, req_valid = 1'b0, abort = 1'b0;
  logic [CH-1:0] req_sel = '0;
  logic [4:0]    req_step = '0;
  logic [CW-1:0] req_count = '0;
  logic          req_ready, pulse, busy, done, aborted;
  logic [CH-1:0] sel_o;
  logic [4:0]    step_o;
  logic [CW-1:0] issued;
  logic signed [23:0] ppm;

  txpippm_step_sequencer #(.CHANNEL_COUNT(CH), .COUNT_WIDTH(CW), .PULSE_INTERVAL(PI)) dut (
    .gtwiz_userclk_tx_usrclk_in(clk), .gtwiz_reset_all_n_in(rst_n),
    .gtwiz_userclk_tx_active_in(tx_act), .req_valid_in(req_valid), .req_ready_out(req_ready),
    .req_sel_in(req_sel), .req_stepsize_in(req_step), .req_count_in(req_count),
    .abort_in(abort), .sel_out(sel_o), .pulse_out(pulse), .stepsize_out(step_o),
    .busy_out(busy), .done_out(done), .aborted_out(aborted),
    .pulses_issued_out(issued), .ppm_offset_out(ppm));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;

  typedef struct {
    bit            is_done;
    int            at;
    logic [CH-1:0] sel;
    logic [4:0]    step;
    int            issued;
    bit            ab;
    int            acc;
  } ev_t;
  ev_t sb[$];
  int  acc_m = 0;

  function automatic void chk(string nm, longint act, longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic int sat_add(int a, int d);
    int r = a + d;
    if (r > 8388607)  r = 8388607;
    if (r < -8388608) r = -8388608;
    return r;
  endfunction

  // Monitor: pops one expected event per observed pulse/done.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && (pulse || done)) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", {pulse, done}, 0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("event_cycle", cyc, e.at);
        chk("event_kind_done", done, e.is_done);
        chk("event_kind_pulse", pulse, !e.is_done);
        chk("sel_out", sel_o, e.sel);
        chk("stepsize_out", step_o, e.step);
        chk("busy_out", busy, 1);
        chk("pulses_issued", issued, e.issued);
        chk("ppm_offset", $signed(ppm), ACC_EN ? e.acc : 0);
        if (e.is_done) chk("aborted_out", aborted, e.ab);
      end
    end
  end

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_pulse"}, pulse, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_aborted"}, aborted, 0);
    chk({tag, "_sel"}, sel_o, 0);
    chk({tag, "_step"}, step_o, 0);
    chk({tag, "_issued"}, issued, 0);
    chk({tag, "_ppm"}, $signed(ppm), 0);
  endtask

  // One request. Offsets are cycles after the accept cycle N; 0 disables.
  task automatic run_req(input logic [CH-1:0] sel, input logic [4:0] step, input int count,
                         input int ab_off, input int drop_off, input int drop_len,
                         input int rst_off, input bit poke);
    int  w, n, aeff, np, done_off, tend;
    bit  abt, was_rst;
    ev_t e;
    w = 0;
    was_rst = 0;
    @(negedge clk);
    while (!req_ready) begin
      if (w++ > 300) begin
        chk("ready_timeout", req_ready, 1);
        return;
      end
      @(negedge clk);
    end
    req_valid = 1'b1;
    req_sel   = sel;
    req_step  = step;
    req_count = CW'(count);
    n = cyc;
    // Reference: pulses at 1+k*PI; an abort at offset A inside the active
    // window [1, count*PI] keeps pulses at or before A and ends at A+1.
    aeff = 1 << 30;
    if (ab_off > 0) aeff = ab_off;
    if (drop_off > 0 && drop_off < aeff) aeff = drop_off;
    abt = (count > 0) && (aeff <= count * PI);
    np = 0;
    for (int k = 0; k < count; k++) begin
      if (abt && (1 + k * PI) > aeff) break;
      e = '{0, n + 1 + k * PI, sel, step, k, 0, acc_m};
      sb.push_back(e);
      acc_m = sat_add(acc_m, step[4] ? -int'(step[3:0]) : int'(step[3:0]));
      np++;
    end
    done_off = abt ? aeff + 1 : 1 + count * PI;
    e = '{1, n + done_off, sel, step, np, abt, acc_m};
    sb.push_back(e);
    tend = done_off + 1;
    if (drop_off > 0 && drop_off + drop_len > tend) tend = drop_off + drop_len;
    if (ab_off > tend) tend = ab_off;
    for (int t = 1; t <= tend; t++) begin
      @(negedge clk);
      req_valid = poke && count > 0 && t <= 2;
      if (req_valid) begin
        req_sel   = CH'($urandom);
        req_step  = 5'($urandom);
        req_count = CW'($urandom_range(0, 3));
      end
      abort  = (t == ab_off);
      tx_act = !(drop_off > 0 && t >= drop_off && t < drop_off + drop_len);
      if (t == rst_off) begin
        #3;
        rst_n = 1'b0;
        sb.delete();
        acc_m = 0;
        #1;
        chk_reset_outputs("midreq_reset");
        req_valid = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        was_rst = 1;
        repeat (PI + 4) @(negedge clk);
        break;
      end
      if (!tx_act) begin
        #1;
        chk("ready_while_tx_low", req_ready, 0);
      end
    end
    abort = 1'b0;
    req_valid = 1'b0;
    tx_act = 1'b1;
    if (!was_rst) begin
      chk("scoreboard_drained", sb.size(), 0);
      chk("issued_hold", issued, np);
      chk("idle_busy", busy, 0);
      #1;
      chk("idle_ready", req_ready, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, ab, dr;
    tx_act = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_req(10'h005, 5'h03, 3, 0, 0, 0, 0, 0);        // nominal 3 pulses
    run_req(10'h2a1, 5'h11, 0, 0, 0, 0, 0, 0);        // zero count
    run_req(10'h0f0, 5'h07, 10, 20, 0, 0, 0, 1);      // abort_in mid-wait, poke while busy
    run_req(10'h100, 5'h1f, 5, 0, 33, 10, 0, 0);      // tx_active drop on pulse 3
    run_req(10'h3ff, 5'h05, 2, 2 * PI, 0, 0, 0, 0);   // abort on final expiry cycle
    run_req(10'h001, 5'h02, 4, 0, 0, 0, 5, 0);        // reset mid-request
    run_req(10'h3ff, 5'h04, 2, 0, 0, 0, 0, 0);        // accumulate +4 x2
    run_req(10'h001, 5'h12, 3, 0, 0, 0, 0, 0);        // accumulate -2 x3

    for (int i = 0; i < 40; i++) begin
      cnt = $urandom_range(0, 6);
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, cnt * PI + 4) : 0;
      dr  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, cnt * PI + 4) : 0;
      run_req(CH'($urandom), 5'($urandom), cnt, ab, dr, $urandom_range(1, 6), 0,
              1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
